// File: rtl/dcache_ctrl.sv
// Data-cache controller: arbitrates one load and one store requester, serves
// load hits in the grant cycle, fills on load misses and writes stores through.
module dcache_ctrl #(
  parameter int IDX_BITS = 5,
  parameter int TAG_BITS = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ld_req,
  input  logic [15:0]         ld_addr,
  output logic                ld_done,
  output logic [63:0]         ld_data,
  input  logic                st_req,
  input  logic [15:0]         st_addr,
  input  logic [63:0]         st_data,
  output logic                st_done,
  output logic                cm_en,
  output logic                cm_wr_en,
  output logic [IDX_BITS-1:0] cm_rd_idx,
  output logic [TAG_BITS-1:0] cm_rd_tag,
  input  logic [63:0]         cm_rd_data,
  input  logic                cm_rd_valid,
  output logic [IDX_BITS-1:0] cm_wr_idx,
  output logic [TAG_BITS-1:0] cm_wr_tag,
  output logic [63:0]         cm_wr_data,
  output logic [1:0]          proc2mem_command,
  output logic [63:0]         proc2mem_addr,
  output logic [63:0]         proc2mem_data,
  input  logic [3:0]          mem2proc_response,
  input  logic [63:0]         mem2proc_data,
  input  logic [3:0]          mem2proc_tag,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
);

  localparam int BLK_BITS = 13;

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_REQ  = 2'd1,
    LD_WAIT = 2'd2,
    ST_REQ  = 2'd3
  } state_t;

  state_t                state_r, state_nxt_s;
  logic                  prio_r, prio_nxt_s;
  logic [3:0]            mem_tag_r, mem_tag_nxt_s;
  logic [BLK_BITS-1:0]   addr_r;
  logic [63:0]           data_r;
  logic [31:0]           hit_r, miss_r;
  logic                  lat_ld_s, lat_st_s, hit_inc_s, miss_inc_s;
  logic [BLK_BITS-1:0]   ld_blk_s, st_blk_s;
  logic                  unused_s;

  assign ld_blk_s   = ld_addr[15:3];
  assign st_blk_s   = st_addr[15:3];
  assign unused_s   = ^{ld_addr[2:0], st_addr[2:0]};
  assign hit_count  = hit_r;
  assign miss_count = miss_r;

  // Next-state, arbitration and all cache/memory-side outputs.
  always_comb begin
    state_nxt_s      = state_r;
    prio_nxt_s       = prio_r;
    mem_tag_nxt_s    = mem_tag_r;
    lat_ld_s         = 1'b0;
    lat_st_s         = 1'b0;
    hit_inc_s        = 1'b0;
    miss_inc_s       = 1'b0;
    ld_done          = 1'b0;
    ld_data          = 64'h0;
    st_done          = 1'b0;
    cm_en            = 1'b0;
    cm_wr_en         = 1'b0;
    cm_rd_idx        = addr_r[IDX_BITS-1:0];
    cm_rd_tag        = addr_r[BLK_BITS-1:IDX_BITS];
    cm_wr_idx        = addr_r[IDX_BITS-1:0];
    cm_wr_tag        = addr_r[BLK_BITS-1:IDX_BITS];
    cm_wr_data       = data_r;
    proc2mem_command = CMD_NONE;
    proc2mem_addr    = {48'h0, addr_r, 3'b000};
    proc2mem_data    = data_r;
    // Outputs stay quiet while reset is held, even if requests are pending.
    if (reset) begin
      case (state_r)
        IDLE: begin
          cm_rd_idx = ld_blk_s[IDX_BITS-1:0];
          cm_rd_tag = ld_blk_s[BLK_BITS-1:IDX_BITS];
          if (ld_req && (!st_req || !prio_r)) begin
            cm_en      = 1'b1;
            prio_nxt_s = 1'b1;
            if (cm_rd_valid) begin
              ld_done   = 1'b1;
              ld_data   = cm_rd_data;
              hit_inc_s = 1'b1;
            end else begin
              lat_ld_s    = 1'b1;
              miss_inc_s  = 1'b1;
              state_nxt_s = LD_REQ;
            end
          end else if (st_req) begin
            cm_en       = 1'b1;
            cm_wr_en    = 1'b1;
            cm_wr_idx   = st_blk_s[IDX_BITS-1:0];
            cm_wr_tag   = st_blk_s[BLK_BITS-1:IDX_BITS];
            cm_wr_data  = st_data;
            prio_nxt_s  = 1'b0;
            lat_st_s    = 1'b1;
            state_nxt_s = ST_REQ;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        LD_REQ: begin
          proc2mem_command = CMD_LOAD;
          if (mem2proc_response != 4'd0) begin
            mem_tag_nxt_s = mem2proc_response;
            state_nxt_s   = LD_WAIT;
          end else begin
            state_nxt_s = LD_REQ;
          end
        end
        LD_WAIT: begin
          // A zero tag means no data this cycle, so it can never match.
          if ((mem2proc_tag != 4'd0) && (mem2proc_tag == mem_tag_r)) begin
            cm_en         = 1'b1;
            cm_wr_en      = 1'b1;
            cm_wr_data    = mem2proc_data;
            ld_done       = 1'b1;
            ld_data       = mem2proc_data;
            mem_tag_nxt_s = 4'd0;
            state_nxt_s   = IDLE;
          end else begin
            state_nxt_s = LD_WAIT;
          end
        end
        ST_REQ: begin
          proc2mem_command = CMD_STORE;
          if (mem2proc_response != 4'd0) begin
            st_done     = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = ST_REQ;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      state_nxt_s = IDLE;
    end
  end

  // Control state: FSM, arbitration priority and outstanding memory tag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      prio_r    <= 1'b0;
      mem_tag_r <= 4'd0;
    end else begin
      state_r   <= state_nxt_s;
      prio_r    <= prio_nxt_s;
      mem_tag_r <= mem_tag_nxt_s;
    end
  end

  // Latched block address and store data for the outstanding transaction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_r <= {BLK_BITS{1'b0}};
      data_r <= 64'h0;
    end else if (lat_ld_s) begin
      addr_r <= ld_blk_s;
    end else if (lat_st_s) begin
      addr_r <= st_blk_s;
      data_r <= st_data;
    end else begin
      addr_r <= addr_r;
      data_r <= data_r;
    end
  end

  // Load hit/miss statistics, wrapping modulo 2^32.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_r  <= 32'd0;
      miss_r <= 32'd0;
    end else begin
      if (hit_inc_s) begin
        hit_r <= hit_r + 32'd1;
      end
      if (miss_inc_s) begin
        miss_r <= miss_r + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: stimulus queues expected completions,
// a negedge monitor pops and compares them; an array models the cache memory.
module tb_dcache_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        ld_req, st_req;
  logic [15:0] ld_addr, st_addr;
  logic [63:0] st_data;
  logic        ld_done, st_done;
  logic [63:0] ld_data;
  logic        cm_en, cm_wr_en, cm_rd_valid;
  logic [4:0]  cm_rd_idx, cm_wr_idx;
  logic [7:0]  cm_rd_tag, cm_wr_tag;
  logic [63:0] cm_rd_data, cm_wr_data;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr, proc2mem_data, mem2proc_data;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic [31:0] hit_count, miss_count;

  typedef struct packed {
    logic        is_st;
    logic [15:0] addr;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   st_cmd_cycles = 0;

  logic [31:0] cv = 32'h0;
  logic [7:0]  ct [32];
  logic [63:0] cd [32];

  dcache_ctrl #(.IDX_BITS(5), .TAG_BITS(8)) dut (
    .clock(clock), .reset(reset),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_done(ld_done), .ld_data(ld_data),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_done(st_done),
    .cm_en(cm_en), .cm_wr_en(cm_wr_en),
    .cm_rd_idx(cm_rd_idx), .cm_rd_tag(cm_rd_tag),
    .cm_rd_data(cm_rd_data), .cm_rd_valid(cm_rd_valid),
    .cm_wr_idx(cm_wr_idx), .cm_wr_tag(cm_wr_tag), .cm_wr_data(cm_wr_data),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
    .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clock = ~clock;

  // Direct-mapped cache memory model: combinational lookup, clocked write.
  always_comb begin
    cm_rd_valid = cv[cm_rd_idx] && (ct[cm_rd_idx] == cm_rd_tag);
    cm_rd_data  = cd[cm_rd_idx];
  end

  always @(posedge clock) begin
    if (cm_wr_en) begin
      cv[cm_wr_idx] <= 1'b1;
      ct[cm_wr_idx] <= cm_wr_tag;
      cd[cm_wr_idx] <= cm_wr_data;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (proc2mem_command == 2'd2) st_cmd_cycles++;
      if (ld_done || st_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'({ld_done, st_done}), 64'd0);
        end else begin
          e = exp_q.pop_front();
          if (e.is_st) begin
            chk("st_done_order", 64'(st_done), 64'd1);
            chk("st_mem_data", proc2mem_data, e.data);
            chk("st_mem_addr", proc2mem_addr, {48'h0, e.addr[15:3], 3'b000});
          end else begin
            chk("ld_done_order", 64'(ld_done), 64'd1);
            chk("ld_data", ld_data, e.data);
          end
        end
      end
    end
  end

  task automatic load_miss(input logic [15:0] a, input logic [3:0] rtag,
                           input logic [63:0] d, input int wait_cyc, input bit foreign);
    logic [3:0] ftags [2];
    ftags[0] = 4'd5;
    ftags[1] = 4'd7;
    exp_q.push_back('{is_st: 1'b0, addr: a, data: d});
    ld_req = 1'b1; ld_addr = a;
    #1 chk("miss_grant_cm_en", 64'(cm_en), 64'd1);
    tick();
    mem2proc_response = rtag;
    #1 chk("ld_cmd", 64'(proc2mem_command), 64'd1);
    chk("ld_cmd_addr", proc2mem_addr, {48'h0, a[15:3], 3'b000});
    tick();
    mem2proc_response = 4'd0;
    repeat (wait_cyc) tick();
    if (foreign) begin
      for (int i = 0; i < 2; i++) begin
        mem2proc_tag = ftags[i]; mem2proc_data = 64'hBAD0_BAD0;
        #1 chk("foreign_no_wr", 64'(cm_wr_en), 64'd0);
        chk("foreign_no_done", 64'(ld_done), 64'd0);
        tick();
      end
    end
    mem2proc_tag = rtag; mem2proc_data = d;
    #1 chk("fill_wr_en", 64'(cm_wr_en), 64'd1);
    chk("fill_wr_tag", 64'(cm_wr_tag), 64'(a[15:8]));
    tick();
    mem2proc_tag = 4'd0; ld_req = 1'b0;
  endtask

  task automatic load_hit(input logic [15:0] a, input logic [63:0] d);
    exp_q.push_back('{is_st: 1'b0, addr: a, data: d});
    ld_req = 1'b1; ld_addr = a;
    #1 chk("hit_same_cycle", 64'(ld_done), 64'd1);
    tick();
    ld_req = 1'b0;
  endtask

  task automatic store(input logic [15:0] a, input logic [63:0] d, input int nrej);
    exp_q.push_back('{is_st: 1'b1, addr: a, data: d});
    st_req = 1'b1; st_addr = a; st_data = d;
    #1 chk("st_grant_wr_en", 64'(cm_wr_en), 64'd1);
    chk("st_grant_wr_data", cm_wr_data, d);
    tick();
    mem2proc_response = 4'd0;
    for (int i = 0; i < nrej; i++) begin
      #1 chk("st_retry_no_done", 64'(st_done), 64'd0);
      tick();
    end
    mem2proc_response = 4'd9;
    #1 chk("st_accept_cmd", 64'(proc2mem_command), 64'd2);
    tick();
    st_req = 1'b0; mem2proc_response = 4'd0;
  endtask

  initial begin
    reset = 1'b0; ld_req = 1'b0; st_req = 1'b0;
    ld_addr = 16'h0; st_addr = 16'h0; st_data = 64'h0;
    mem2proc_response = 4'd0; mem2proc_tag = 4'd0; mem2proc_data = 64'h0;
    tick();
    chk("rst_ld_done", 64'(ld_done), 64'd0);
    chk("rst_st_done", 64'(st_done), 64'd0);
    chk("rst_cm_en", 64'(cm_en), 64'd0);
    chk("rst_cm_wr_en", 64'(cm_wr_en), 64'd0);
    chk("rst_cmd", 64'(proc2mem_command), 64'd0);
    chk("rst_hits", 64'(hit_count), 64'd0);
    chk("rst_misses", 64'(miss_count), 64'd0);
    reset = 1'b1;
    tick();

    // Cold miss with a 5-cycle memory latency, then a same-cycle hit.
    load_miss(16'h0040, 4'd3, 64'hDEAD_BEEF, 5, 1'b0);
    chk("miss_count_1", 64'(miss_count), 64'd1);
    load_hit(16'h0040, 64'hDEAD_BEEF);
    chk("hit_count_1", 64'(hit_count), 64'd1);

    // Write-through store rejected twice, then a hit on the stored data.
    st_cmd_cycles = 0;
    store(16'h0040, 64'h1234, 2);
    chk("store_cmd_cycles", 64'(st_cmd_cycles), 64'd3);
    load_hit(16'h0040, 64'h1234);
    chk("hit_count_2", 64'(hit_count), 64'd2);

    // Foreign tags 5 and 7 precede the matching tag 3.
    load_miss(16'h0100, 4'd3, 64'h0100_CAFE, 1, 1'b1);
    chk("miss_count_2", 64'(miss_count), 64'd2);

    // Both requesters held after reset: load, store, load.
    reset = 1'b0; tick(); reset = 1'b1;
    exp_q.push_back('{is_st: 1'b0, addr: 16'h0040, data: 64'h1234});
    exp_q.push_back('{is_st: 1'b1, addr: 16'h0080, data: 64'hAAAA});
    exp_q.push_back('{is_st: 1'b0, addr: 16'h0040, data: 64'h1234});
    ld_req = 1'b1; ld_addr = 16'h0040;
    st_req = 1'b1; st_addr = 16'h0080; st_data = 64'hAAAA;
    mem2proc_response = 4'd2;
    #1 chk("alt_first_load", 64'(ld_done), 64'd1);
    tick();
    chk("alt_store_grant", 64'(cm_wr_en), 64'd1);
    chk("alt_store_no_ld", 64'(ld_done), 64'd0);
    tick();
    chk("alt_store_done", 64'(st_done), 64'd1);
    tick();
    chk("alt_second_load", 64'(ld_done), 64'd1);
    tick();
    ld_req = 1'b0; st_req = 1'b0; mem2proc_response = 4'd0;
    chk("alt_hits", 64'(hit_count), 64'd2);

    // Reset during LD_WAIT discards the miss; the late tag is ignored.
    ld_req = 1'b1; ld_addr = 16'h0180;
    tick();
    mem2proc_response = 4'd3;
    tick();
    mem2proc_response = 4'd0;
    tick();
    reset = 1'b0; ld_req = 1'b0;
    #1 chk("midrst_cm_en", 64'(cm_en), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    mem2proc_tag = 4'd3; mem2proc_data = 64'h5555;
    #1 chk("late_tag_no_done", 64'(ld_done), 64'd0);
    chk("late_tag_no_wr", 64'(cm_wr_en), 64'd0);
    chk("midrst_hits", 64'(hit_count), 64'd0);
    chk("midrst_misses", 64'(miss_count), 64'd0);
    tick();
    mem2proc_tag = 4'd0;

    // Same index, different tags: every access conflicts.
    load_miss(16'h0840, 4'd4, 64'h0840_0001, 2, 1'b0);
    load_miss(16'h0040, 4'd6, 64'h0040_0002, 1, 1'b0);
    load_miss(16'h0840, 4'd15, 64'h0840_0003, 0, 1'b0);
    chk("conflict_misses", 64'(miss_count), 64'd3);
    chk("conflict_hits", 64'(hit_count), 64'd0);

    repeat (3) tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
